// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// with valid/ready handshakes, carry/overflow/zero flags and optional saturation.
module add_sub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_s,
  input  logic             i_sat,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sat_q, sat_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  // One digit of the ripple: low DIGIT bits of the shifted operands plus carry.
  logic [DIGIT:0]       digit_sum;
  logic [WIDTH+DIGIT-1:0] shift_cat;
  logic [WIDTH-1:0]     res_shift;
  logic                 final_cout;
  logic                 final_ovf;
  logic [WIDTH-1:0]     sat_val;
  logic [WIDTH-1:0]     final_sum;

  assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + (DIGIT+1)'(carry_q);

  // New digit enters from the MSB side; the concat form also covers DIGIT == WIDTH.
  assign shift_cat = {digit_sum[DIGIT-1:0], res_q};
  assign res_shift = shift_cat[WIDTH+DIGIT-1:DIGIT];

  // On the last digit a_q/b_q hold the operand MSBs in bit DIGIT-1, so
  // a^b^sum at that bit recovers the carry into bit WIDTH-1.
  assign final_cout = digit_sum[DIGIT];
  assign final_ovf  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digit_sum[DIGIT-1] ^ digit_sum[DIGIT];
  assign sat_val    = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
  assign final_sum  = (final_ovf && sat_q) ? sat_val : res_shift;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sat_d   = sat_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b ^ {WIDTH{i_s}};
          sat_d   = i_sat;
          carry_d = i_s;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        res_d   = res_shift;
        if (cnt_q == LAST) begin
          sum_d   = final_sum;
          cout_d  = final_cout;
          ovf_d   = final_ovf;
          zero_d  = (final_sum == '0);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves no
  // stale operands, carry or count behind for the next one.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so all registers see pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sat_q   <= sat_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_ovf   = ovf_q;
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial: three instances cover the default,
// single-cycle (DIGIT == WIDTH) and 8-bit/2-bit-digit configurations.
module tb_add_sub_serial;

  localparam int NI = 3;
  localparam int W_OF [NI] = '{16, 16, 8};
  localparam int N_OF [NI] = '{4, 1, 4};

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] a_v     [NI];
  logic [15:0] b_v     [NI];
  logic        s_v     [NI];
  logic        sat_v   [NI];
  logic        valid_v [NI];
  logic        irdy_v  [NI];

  wire         ordy   [NI];
  wire         ovalid [NI];
  wire         cout_w [NI];
  wire         ovf_w  [NI];
  wire         zero_w [NI];
  wire [15:0]  sum_w  [NI];
  wire [7:0]   sum8;

  res_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  add_sub_serial #(.WIDTH(16), .DIGIT(4)) u0 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid_v[0]), .o_ready(ordy[0]),
    .i_a(a_v[0]), .i_b(b_v[0]), .i_s(s_v[0]), .i_sat(sat_v[0]),
    .o_valid(ovalid[0]), .i_ready(irdy_v[0]), .o_sum(sum_w[0]),
    .o_cout(cout_w[0]), .o_ovf(ovf_w[0]), .o_zero(zero_w[0])
  );

  add_sub_serial #(.WIDTH(16), .DIGIT(16)) u1 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid_v[1]), .o_ready(ordy[1]),
    .i_a(a_v[1]), .i_b(b_v[1]), .i_s(s_v[1]), .i_sat(sat_v[1]),
    .o_valid(ovalid[1]), .i_ready(irdy_v[1]), .o_sum(sum_w[1]),
    .o_cout(cout_w[1]), .o_ovf(ovf_w[1]), .o_zero(zero_w[1])
  );

  add_sub_serial #(.WIDTH(8), .DIGIT(2)) u2 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid_v[2]), .o_ready(ordy[2]),
    .i_a(a_v[2][7:0]), .i_b(b_v[2][7:0]), .i_s(s_v[2]), .i_sat(sat_v[2]),
    .o_valid(ovalid[2]), .i_ready(irdy_v[2]), .o_sum(sum8),
    .o_cout(cout_w[2]), .o_ovf(ovf_w[2]), .o_zero(zero_w[2])
  );
  assign sum_w[2] = {8'h00, sum8};

  // Reference: full-width integer arithmetic, overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic sat);
    logic [31:0] mask;
    logic [31:0] aa;
    logic [31:0] bb;
    logic [31:0] full;
    logic [31:0] raw;
    res_t r;
    mask   = (32'd1 << w) - 32'd1;
    aa     = {16'h0000, a} & mask;
    bb     = (s ? ~{16'h0000, b} : {16'h0000, b}) & mask;
    full   = aa + bb + {31'd0, s};
    raw    = full & mask;
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (raw[w-1] != aa[w-1]);
    if (r.ovf && sat) raw = aa[w-1] ? (32'd1 << (w - 1)) : (mask >> 1);
    r.sum  = raw[15:0];
    r.zero = (raw == 32'd0);
    return r;
  endfunction

  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic sat, input bit hold, input string name);
    int   lat;
    res_t e;
    @(negedge clk);
    lat = 0;
    while (!ordy[sel] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (ordy[sel] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: o_ready=%b required 1", name, ordy[sel]);
      return;
    end
    a_v[sel]     = a;
    b_v[sel]     = b;
    s_v[sel]     = s;
    sat_v[sel]   = sat;
    valid_v[sel] = 1'b1;
    irdy_v[sel]  = !hold;
    exp_q.push_back(model(W_OF[sel], a, b, s, sat));
    @(posedge clk); #1;
    valid_v[sel] = 1'b0;
    a_v[sel]     = 16'($urandom);
    b_v[sel]     = 16'($urandom);
    s_v[sel]     = ~s;
    sat_v[sel]   = ~sat;
    checks++;
    if (ordy[sel] !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: o_ready=%b required 0", name, ordy[sel]);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ovalid[sel] !== 1'b1 && lat < 20);
    checks++;
    if (lat != N_OF[sel] || ovalid[sel] !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (o_valid=%b) required %0d", name, lat,
               ovalid[sel], N_OF[sel]);
    end
    e = exp_q.pop_front();
    checks++;
    if (sum_w[sel] !== e.sum) begin
      errors++;
      $display("FAIL %s sum: got %h required %h", name, sum_w[sel], e.sum);
    end
    checks++;
    if ({cout_w[sel], ovf_w[sel], zero_w[sel]} !== {e.cout, e.ovf, e.zero}) begin
      errors++;
      $display("FAIL %s flags cout/ovf/zero: got %b%b%b required %b%b%b", name,
               cout_w[sel], ovf_w[sel], zero_w[sel], e.cout, e.ovf, e.zero);
    end
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        a_v[sel]     = 16'($urandom);
        b_v[sel]     = 16'($urandom);
        valid_v[sel] = k[0] ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ovalid[sel] !== 1'b1 || ordy[sel] !== 1'b0 || sum_w[sel] !== e.sum ||
            {cout_w[sel], ovf_w[sel], zero_w[sel]} !== {e.cout, e.ovf, e.zero}) begin
          errors++;
          $display("FAIL %s hold%0d: valid=%b ready=%b sum=%h required valid=1 ready=0 sum=%h",
                   name, k, ovalid[sel], ordy[sel], sum_w[sel], e.sum);
        end
      end
      // Request held high across the handshake edge must not be accepted.
      @(negedge clk);
      valid_v[sel] = 1'b1;
      irdy_v[sel]  = 1'b1;
    end
    @(posedge clk); #1;
    valid_v[sel] = 1'b0;
    checks++;
    if (ovalid[sel] !== 1'b0 || ordy[sel] !== 1'b1 || sum_w[sel] !== e.sum) begin
      errors++;
      $display("FAIL %s release: valid=%b ready=%b sum=%h required valid=0 ready=1 sum=%h",
               name, ovalid[sel], ordy[sel], sum_w[sel], e.sum);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ordy[i] !== 1'b1 || ovalid[i] !== 1'b0 || sum_w[i] !== 16'h0000 ||
          {cout_w[i], ovf_w[i], zero_w[i]} !== 3'b000) begin
        errors++;
        $display("FAIL reset%0d: ready=%b valid=%b sum=%h flags=%b%b%b required 1 0 0000 000",
                 i, ordy[i], ovalid[i], sum_w[i], cout_w[i], ovf_w[i], zero_w[i]);
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_add();
    do_op(0, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, "add");
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_wrap");
  endtask

  task automatic test_subtract();
    do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, "sub_borrow");
    do_op(0, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, "sub_zero");
  endtask

  task automatic test_overflow();
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "ovf_nosat");
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, "ovf_sat_pos");
    do_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, "ovf_sat_neg");
    do_op(0, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, "ovf_sat_negadd");
  endtask

  task automatic test_backpressure();
    do_op(0, 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    a_v[0]     = 16'h1234;
    b_v[0]     = 16'h1111;
    s_v[0]     = 1'b0;
    sat_v[0]   = 1'b0;
    valid_v[0] = 1'b1;
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (ordy[0] !== 1'b1 || ovalid[0] !== 1'b0 || sum_w[0] !== 16'h0000 ||
        {cout_w[0], ovf_w[0], zero_w[0]} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: ready=%b valid=%b sum=%h flags=%b%b%b required 1 0 0000 000",
               ordy[0], ovalid[0], sum_w[0], cout_w[0], ovf_w[0], zero_w[0]);
    end
    @(negedge clk);
    rstn = 1'b1;
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_sweep();
    do_op(1, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, "d16_add");
    do_op(1, 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, "d16_sub");
    do_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, "d16_sat");
    do_op(2, 16'h0012, 16'h0001, 1'b0, 1'b0, 1'b0, "w8_add");
    do_op(2, 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, "w8_sub");
    do_op(2, 16'h0080, 16'h0001, 1'b1, 1'b1, 1'b0, "w8_sat");
    for (int i = 0; i < 60; i++) begin
      int sel;
      logic [15:0] ra;
      logic [15:0] rb;
      sel = i % NI;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (W_OF[sel] == 8) begin
        ra[15:8] = 8'h00;
        rb[15:8] = 8'h00;
      end
      do_op(sel, ra, rb, 1'($urandom), 1'($urandom), 1'b0, "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      a_v[i]     = '0;
      b_v[i]     = '0;
      s_v[i]     = 1'b0;
      sat_v[i]   = 1'b0;
      valid_v[i] = 1'b0;
      irdy_v[i]  = 1'b1;
    end
    test_reset();
    test_add();
    test_subtract();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
